sdram_write_sched: RTL

//  Schedules writes onto the single SDRAM write port, shared by two sources:
//  - scene loader: write pulses, no backpressure.
//  - frame-buffer writer: req/ack handshake.

---
 rtl/sdram_write_sched_if.sv | 35 +++
 rtl/sdram_write_sched.sv | 129 ++++++++++++
 2 files changed

// File: rtl/sdram_write_sched_if.sv
// Bus bundle for the SDRAM write scheduler: loader pulses, fb handshake and
// the single SDRAM write port.
interface sdram_write_sched_if #(
   parameter int AW = 25,
   parameter int DW = 32
);
   logic [AW-1:0] sl_addr;
   logic [DW-1:0] sl_io;
   logic          sl_we;
   logic          sl_done;
   logic          fb_req;
   logic [AW-1:0] fb_addr;
   logic [DW-1:0] fb_data;
   logic          fb_ack;
   logic          sd_req;
   logic [AW-1:0] sd_addr;
   logic [DW-1:0] sd_wdata;
   logic          sd_ack;
   logic          sl_overflow;
   logic          load_done;

   modport slave (
      input  sl_addr, sl_io, sl_we, sl_done,
      input  fb_req, fb_addr, fb_data,
      input  sd_ack,
      output fb_ack, sd_req, sd_addr, sd_wdata, sl_overflow, load_done
   );

   modport master (
      output sl_addr, sl_io, sl_we, sl_done,
      output fb_req, fb_addr, fb_data,
      output sd_ack,
      input  fb_ack, sd_req, sd_addr, sd_wdata, sl_overflow, load_done
   );
endinterface

// File: rtl/sdram_write_sched.sv
// Arbitrates the scene loader (FIFO-buffered pulses) and the frame-buffer
// writer (req/ack) onto one registered SDRAM write port.
//
// state   | meaning
// IDLE    | output register empty, sd_req low
// BUSY_SL | loader write presented on the SDRAM port
// BUSY_FB | frame-buffer write presented on the SDRAM port
module sdram_write_sched #(
   parameter int DEPTH    = 8,
   parameter int AW       = 25,
   parameter int DW       = 32,
   parameter int SL_BURST = 4
) (
   input  logic clk,
   input  logic rst,
   sdram_write_sched_if.slave bus
);
   localparam int PW = $clog2(DEPTH) + 1;
   localparam int CW = $clog2(SL_BURST + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(SL_BURST);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_SL = 2'd1,
      BUSY_FB = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [AW-1:0] fifo_addr [DEPTH];
   logic [DW-1:0] fifo_data [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] sl_cnt, sl_cnt_nx;

   logic fifo_empty, fifo_full;
   logic fb_pend, free, grant_sl, grant_fb, push;
   logic sl_outstanding, done_now;

   logic          sd_req_q, fb_ack_q, overflow_q, done_seen_q, load_done_q;
   logic [AW-1:0] sd_addr_q;
   logic [DW-1:0] sd_wdata_q;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]) &&
                       (wr_ptr[PW-1] != rd_ptr[PW-1]);

   // The request is still held high during the fb_ack cycle; it is already ours.
   assign fb_pend = bus.fb_req & ~fb_ack_q;
   assign free    = (state == IDLE) | bus.sd_ack;

   assign push           = bus.sl_we & (~fifo_full | grant_sl);
   assign sl_outstanding = (state == BUSY_SL) & ~bus.sd_ack;
   assign done_now       = bus.sl_done | done_seen_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         sl_cnt <= '0;
      end else begin
         state  <= state_nx;
         sl_cnt <= sl_cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      sl_cnt_nx = sl_cnt;
      grant_sl  = 1'b0;
      grant_fb  = 1'b0;
      if (free) begin
         if (!fifo_empty && !(fb_pend && sl_cnt == BURST_MAX)) begin
            grant_sl = 1'b1;
            state_nx = BUSY_SL;
            if (sl_cnt != BURST_MAX) sl_cnt_nx = sl_cnt + 1'b1;
         end else if (fb_pend) begin
            grant_fb  = 1'b1;
            state_nx  = BUSY_FB;
            sl_cnt_nx = '0;
         end else begin
            state_nx = IDLE;
         end
      end
      if (!bus.fb_req) sl_cnt_nx = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sd_req_q    <= 1'b0;
         sd_addr_q   <= '0;
         sd_wdata_q  <= '0;
         fb_ack_q    <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         overflow_q  <= 1'b0;
         done_seen_q <= 1'b0;
         load_done_q <= 1'b0;
      end else begin
         fb_ack_q <= grant_fb;
         if (free) sd_req_q <= grant_sl | grant_fb;
         if (grant_sl) begin
            sd_addr_q  <= fifo_addr[rd_ptr[PW-2:0]];
            sd_wdata_q <= fifo_data[rd_ptr[PW-2:0]];
            rd_ptr     <= rd_ptr + 1'b1;
         end else if (grant_fb) begin
            sd_addr_q  <= bus.fb_addr;
            sd_wdata_q <= bus.fb_data;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (bus.sl_we && !push) overflow_q <= 1'b1;
         if (bus.sl_done) done_seen_q <= 1'b1;
         if (done_now && fifo_empty && !sl_outstanding) load_done_q <= 1'b1;
      end
   end

   // Storage needs no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr[PW-2:0]] <= bus.sl_addr;
         fifo_data[wr_ptr[PW-2:0]] <= bus.sl_io;
      end
   end

   assign bus.sd_req      = sd_req_q;
   assign bus.sd_addr     = sd_addr_q;
   assign bus.sd_wdata    = sd_wdata_q;
   assign bus.fb_ack      = fb_ack_q;
   assign bus.sl_overflow = overflow_q;
   assign bus.load_done   = load_done_q;
endmodule
